// File: rtl/data_array_1r1w.sv
// data_array_1r1w: single-clock 1-read/1-write data array with per-lane write
// mask, registered read port (valid/err flags) and a post-reset clear
// sequencer that zeroes every entry before the ports are opened.
// Optional feature macro: DATA_ARRAY_RW_BYPASS_EN -- forwards same-cycle,
// same-address write data (merged per lane) to the read port. Without it a
// colliding read returns the old entry.
module data_array_1r1w #(
  parameter int unsigned DEPTH  = 40,
  parameter int unsigned WIDTH  = 128,
  parameter int unsigned GRAN   = 8,
  localparam int unsigned LANES  = WIDTH / GRAN,
  localparam int unsigned ADDR_W = $clog2(DEPTH)
) (
  input  logic              clock,
  input  logic              reset_n,
  output logic              init_busy,
  input  logic              R0_en,
  input  logic [ADDR_W-1:0] R0_addr,
  output logic              R0_valid,
  output logic [WIDTH-1:0]  R0_data,
  output logic              R0_err,
  input  logic              W0_en,
  input  logic [ADDR_W-1:0] W0_addr,
  input  logic [LANES-1:0]  W0_mask,
  input  logic [WIDTH-1:0]  W0_data
);

  localparam logic [0:0] S_CLEAR = 1'b0;
  localparam logic [0:0] S_READY = 1'b1;

  // Extended by one bit so the range test also works when DEPTH is a power of two.
  localparam logic [ADDR_W:0]   DEPTH_EXT = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(DEPTH - 1);

  logic [0:0]        state;
  logic [ADDR_W-1:0] clr_cnt;
  logic [WIDTH-1:0]  mem [DEPTH];

  logic              ready;
  logic              rd_in_range;
  logic              wr_in_range;
  logic              rd_acc;
  logic              wr_acc;
  logic [WIDTH-1:0]  rd_word;

  assign ready       = (state == S_READY);
  assign init_busy   = (state == S_CLEAR);
  assign rd_in_range = ({1'b0, R0_addr} < DEPTH_EXT);
  assign wr_in_range = ({1'b0, W0_addr} < DEPTH_EXT);
  assign rd_acc      = ready && R0_en;
  assign wr_acc      = ready && W0_en && wr_in_range;

  // Clear sequencer: walk entries 0..DEPTH-1, then open the ports for good.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state   <= S_CLEAR;
      clr_cnt <= '0;
    end else if (state == S_CLEAR) begin
      if (clr_cnt == LAST_IDX) begin
        state   <= S_READY;
        clr_cnt <= '0;
      end else begin
        clr_cnt <= clr_cnt + 1'b1;
      end
    end
  end

  // Storage: zero fill during clear, otherwise per-lane masked writes.
  always_ff @(posedge clock) begin
    if (state == S_CLEAR) begin
      mem[clr_cnt] <= '0;
    end else if (wr_acc) begin
      for (int unsigned i = 0; i < LANES; i++) begin
        if (W0_mask[i]) begin
          mem[W0_addr][i*GRAN +: GRAN] <= W0_data[i*GRAN +: GRAN];
        end
      end
    end
  end

`ifdef DATA_ARRAY_RW_BYPASS_EN
  // Read word with same-address write forwarded lane by lane.
  always_comb begin
    rd_word = mem[R0_addr];
    if (wr_acc && (W0_addr == R0_addr)) begin
      for (int unsigned i = 0; i < LANES; i++) begin
        if (W0_mask[i]) begin
          rd_word[i*GRAN +: GRAN] = W0_data[i*GRAN +: GRAN];
        end
      end
    end
  end
`else
  // Read word straight from the array (read-before-write on collision).
  always_comb begin
    rd_word = mem[R0_addr];
  end
`endif

  // Registered read port: valid/err pulse for one cycle, data holds.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      R0_valid <= 1'b0;
      R0_err   <= 1'b0;
      R0_data  <= '0;
    end else begin
      R0_valid <= rd_acc;
      R0_err   <= rd_acc && !rd_in_range;
      if (rd_acc) begin
        R0_data <= rd_in_range ? rd_word : '0;
      end
    end
  end

endmodule

// File: doc/data_array_1r1w.md
# data_array_1r1w

Parametrised single-clock 1-read/1-write data array: the next generation of the fixed-size data-cache arrays. Adds a per-lane write mask, a registered read port with a valid flag, and a post-reset clear sequencer, so contents are defined after every reset. An optional compile-time bypass forwards same-cycle write data to the read port. It sits between the cache controller and the data storage and serves as a drop-in for all data/tag array sizes.

## Interface
- DEPTH, 40: number of entries; any value ≥ 2, not required to be a power of two.
- WIDTH, 128: data bits per entry.
- GRAN, 8: bits per mask lane; WIDTH must be a multiple of GRAN. LANES = WIDTH/GRAN.
- ADDR_W, $clog2(DEPTH): address width; derived, never overridden.

Ports:
- clock  in  1  sole clock; all state updates on its rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- init_busy  out  1  high while the clear sequencer runs; both ports are ignored while high.
- R0_en  in  1  read request.
- R0_addr  in  ADDR_W  read address.
- R0_valid  out  1  R0_data holds the result of the read accepted in the previous cycle.
- R0_data  out  WIDTH  registered read data.
- R0_err  out  1  with R0_valid: the accepted read address was ≥ DEPTH.
- W0_en  in  1  write request.
- W0_addr  in  ADDR_W  write address.
- W0_mask  in  LANES  lane i writes W0_data[i*GRAN +: GRAN].
- W0_data  in  WIDTH  write data.

## Operation
- Reset values: init_busy=1, R0_valid=0, R0_data=0, R0_err=0, clear counter=0, state CLEAR. Array contents are not reset directly.
- State CLEAR:
  - Each cycle, write all-zero to entry[counter], then increment counter.
  - After entry DEPTH-1 is written, go to READY and drop init_busy.
  - CLEAR lasts exactly DEPTH cycles.
- While CLEAR: R0_en and W0_en are ignored, R0_valid stays 0, and no request is queued.
- State READY: one read and one write may be accepted per cycle. READY is left only by reset.
- Write, accepted when W0_en=1 in READY:
  - Lanes with W0_mask=1 take the new data; other lanes keep their value.
  - W0_mask=0 means no change.
  - W0_addr ≥ DEPTH: the write is dropped silently.
- Read, accepted when R0_en=1 in READY:
  - Next cycle, R0_valid=1 and R0_data = entry[R0_addr].
  - R0_addr ≥ DEPTH: R0_data=0 and R0_err=1.
- Read output holding:
  - R0_data holds until the next accepted read.
  - R0_valid is 1 only in the cycle after an accepted read.
  - R0_err is 0 whenever R0_valid=0.
- Read and write to the same in-range address in the same cycle: the result is set by the bypass configuration (see Configuration).
- Read and write to different addresses in the same cycle are independent.
- reset_n asserted at any time, including mid-CLEAR or mid-read:
  - Outputs return to reset values immediately.
  - On release, CLEAR restarts at entry 0.

## Timing
- Read latency is 1 cycle, address to registered R0_data.
- Write is visible to a read accepted in the following cycle.
- init_busy falls DEPTH cycles after the first rising edge of clock with reset_n high.
- Inputs must be stable around the rising edge of clock.
- No combinational path from any input to any output.

## Configuration
- DATA_ARRAY_RW_BYPASS_EN defined: a same-cycle, same-address read returns the merged result. Masked lanes come from W0_data; unmasked lanes come from the old entry.
- Not defined: a same-cycle, same-address read returns the old entry (read-before-write). No forwarding mux is built.

## Test plan
- Reset release with DEPTH=40 → init_busy high for exactly 40 cycles. After that, a read of every address returns 0 with R0_err=0.
- Write entry 5 = 0xA5 repeated, mask all-ones; next cycle read 5 → R0_valid=1, R0_data = 0xA5 repeated. Then write 0x00 with mask 0x0001; read 5 → lane 0 = 0x00, other lanes = 0xA5.
- Same-cycle write 0x11 repeated and read, both to entry 7 (old value 0) → R0_data = 0x11 repeated with DATA_ARRAY_RW_BYPASS_EN, 0 without it.
- Read address 45 → R0_valid=1, R0_err=1, R0_data=0. Write to address 63 → no entry changes, checked by a full read sweep.
- Assert reset_n at cycle 20 of CLEAR after writing nothing → outputs return to reset values at once. After release, init_busy is high for 40 cycles again.
- R0_en and W0_en held high during CLEAR with W0_data all-ones → R0_valid stays 0, and all entries read 0 after CLEAR.
